// File: rtl/conv_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_alu_sequencer
// Description : Sequences the combinational convolution ALU. Keeps a
//               double-buffered kernel/divider bank, registers one pixel
//               window per beat into the ALU and registers the ALU result
//               onto an output valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_alu_sequencer #(
   parameter int NTAPS         = 9,
   parameter int DWIDTH_DAT    = 12,
   parameter int DWIDTH_KERNEL = 5,
   parameter int DWIDTH_DIV    = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   // configuration port (shadow bank)
   input  logic                             cfg_we,
   input  logic [$clog2(NTAPS+1)-1:0]       cfg_addr,
   input  logic [DWIDTH_KERNEL-1:0]         cfg_wdata,
   input  logic                             cfg_commit,
   output logic                             commit_pending,
   // window input stream
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [NTAPS*DWIDTH_DAT-1:0]      s_data,
   input  logic                             s_sof,
   input  logic                             s_last,
   // ALU interface
   output logic [NTAPS*DWIDTH_DAT-1:0]      alu_din,
   output logic [NTAPS*DWIDTH_KERNEL-1:0]   alu_kernel,
   output logic [DWIDTH_DIV-1:0]            alu_div,
   input  logic [DWIDTH_DAT-1:0]            alu_dout,
   // result output stream
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [DWIDTH_DAT-1:0]            m_data,
   output logic                             m_last,
   // status
   output logic                             frame_err
);

   localparam int c_ADDR_W = $clog2(NTAPS+1);
   localparam int c_KBUS_W = NTAPS*DWIDTH_KERNEL;
   localparam int c_DBUS_W = NTAPS*DWIDTH_DAT;
   localparam logic [c_ADDR_W-1:0] c_DIV_ADDR = c_ADDR_W'(NTAPS);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FRAME = 1'b1
   } state_t;

   state_t                  r_state;

   // configuration banks
   logic [c_KBUS_W-1:0]     r_shadow_k;
   logic [DWIDTH_DIV-1:0]   r_shadow_div;
   logic [c_KBUS_W-1:0]     r_active_k;
   logic [DWIDTH_DIV-1:0]   r_active_div;
   logic [c_KBUS_W-1:0]     w_shadow_k_nxt;
   logic [DWIDTH_DIV-1:0]   w_shadow_div_nxt;
   logic                    r_commit_pending;
   logic                    r_frame_err;

   // stage 1 (ALU operands)
   logic                    r_st1_valid;
   logic                    r_st1_last;
   logic [c_DBUS_W-1:0]     r_alu_din;
   logic [c_KBUS_W-1:0]     r_alu_kernel;
   logic [DWIDTH_DIV-1:0]   r_alu_div;

   // stage 2 (result)
   logic                    r_m_valid;
   logic [DWIDTH_DAT-1:0]   r_m_data;
   logic                    r_m_last;

   // handshake / control
   logic                    w_adv1;
   logic                    w_adv2;
   logic                    w_accept;
   logic                    w_swap_event;
   logic                    w_swap;

   // Pipeline advance: each stage moves when it is empty or its consumer moves.
   assign w_adv2   = !r_m_valid || m_ready;
   assign w_adv1   = !r_st1_valid || w_adv2;
   assign w_accept = s_valid && w_adv1;

   // A pending (or same-edge) commit is applied when the frame is closed and
   // idle, or on the start-of-frame beat so the whole new frame uses it.
   assign w_swap_event = ((r_state == S_IDLE) && !w_accept) || (w_accept && s_sof);
   assign w_swap       = (r_commit_pending || cfg_commit) && w_swap_event;

   // Shadow bank contents including this edge's write, so a write landing on
   // the swap edge is carried into the active bank.
   always_comb begin
      w_shadow_k_nxt   = r_shadow_k;
      w_shadow_div_nxt = r_shadow_div;
      if (cfg_we) begin
         for (int i = 0; i < NTAPS; i++) begin
            if (cfg_addr == c_ADDR_W'(i)) begin
               w_shadow_k_nxt[i*DWIDTH_KERNEL +: DWIDTH_KERNEL] = cfg_wdata;
            end
         end
         if (cfg_addr == c_DIV_ADDR) begin
            w_shadow_div_nxt = cfg_wdata[DWIDTH_DIV-1:0];
         end
      end
   end

   // Shadow bank register; addresses above the divider slot fall through unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow_k   <= '0;
         r_shadow_div <= '0;
      end else begin
         r_shadow_k   <= w_shadow_k_nxt;
         r_shadow_div <= w_shadow_div_nxt;
      end
   end

   // Frame-tracking FSM with commit handshake, active bank and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_commit_pending <= 1'b0;
         r_frame_err      <= 1'b0;
         r_active_k       <= '0;
         r_active_div     <= '0;
      end else begin
         if (w_swap) begin
            r_active_k       <= w_shadow_k_nxt;
            r_active_div     <= w_shadow_div_nxt;
            r_commit_pending <= 1'b0;
         end else if (cfg_commit) begin
            r_commit_pending <= 1'b1;
         end

         if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (s_sof && !s_last) begin
                     r_state <= S_FRAME;
                  end
               end
               S_FRAME: begin
                  if (s_sof) begin
                     r_frame_err <= 1'b1;
                  end
                  if (s_last) begin
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Stage 1: capture the accepted window with the bank it must use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st1_valid  <= 1'b0;
         r_st1_last   <= 1'b0;
         r_alu_din    <= '0;
         r_alu_kernel <= '0;
         r_alu_div    <= '0;
      end else if (w_adv1) begin
         r_st1_valid <= w_accept;
         if (w_accept) begin
            r_alu_din  <= s_data;
            r_st1_last <= s_last;
            // a swap coinciding with an accepted beat only happens on s_sof
            if (w_swap) begin
               r_alu_kernel <= w_shadow_k_nxt;
               r_alu_div    <= w_shadow_div_nxt;
            end else begin
               r_alu_kernel <= r_active_k;
               r_alu_div    <= r_active_div;
            end
         end
      end
   end

   // Stage 2: register the combinational ALU result; hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_last  <= 1'b0;
      end else if (w_adv2) begin
         r_m_valid <= r_st1_valid;
         if (r_st1_valid) begin
            r_m_data <= alu_dout;
            r_m_last <= r_st1_last;
         end
      end
   end

   assign s_ready        = w_adv1;
   assign commit_pending = r_commit_pending;
   assign frame_err      = r_frame_err;
   assign alu_din        = r_alu_din;
   assign alu_kernel     = r_alu_kernel;
   assign alu_div        = r_alu_div;
   assign m_valid        = r_m_valid;
   assign m_data         = r_m_data;
   assign m_last         = r_m_last;

endmodule
`default_nettype wire

// File: doc/conv_alu_sequencer.md
Name: conv_alu_sequencer

Overview:
- Sequences the combinational convolution ALU. Holds the kernel coefficients and divider shift in a double-buffered configuration bank.
- Accepts one pixel window per beat on a valid/ready stream and drives the window, kernel and divider into the ALU through a register stage.
- Captures the ALU result into an output register and presents it on a valid/ready stream.
- Sits between the line-buffer/window generator and the frame-buffer writer.

Parameters:
- NTAPS, 9, number of window taps (3x3).
- DWIDTH_DAT, 12, pixel width: R[11:8], G[7:4], B[3:0], 4 bits each.
- DWIDTH_KERNEL, 5, signed coefficient width.
- DWIDTH_DIV, 3, right-shift amount width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- cfg_we  in  1  write strobe into the shadow bank.
- cfg_addr  in  $clog2(NTAPS+1)  0..NTAPS-1 select a tap; NTAPS selects div.
- cfg_wdata  in  DWIDTH_KERNEL  coefficient; div uses bits [DWIDTH_DIV-1:0].
- cfg_commit  in  1  pulse: request shadow-to-active swap.
- commit_pending  out  1  swap requested, not yet applied.
- s_valid  in  1  window beat valid.
- s_ready  out  1  window beat accepted when s_valid&&s_ready.
- s_data  in  NTAPS*DWIDTH_DAT  window; tap i at [DW*(i+1)-1:DW*i].
- s_sof  in  1  beat is first window of a frame.
- s_last  in  1  beat is last window of a frame.
- alu_din  out  NTAPS*DWIDTH_DAT  to ALU.
- alu_kernel  out  NTAPS*DWIDTH_KERNEL  to ALU.
- alu_div  out  DWIDTH_DIV  to ALU.
- alu_dout  in  DWIDTH_DAT  from ALU (combinational from alu_*).
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accept.
- m_data  out  DWIDTH_DAT  result.
- m_last  out  1  result belongs to the s_last beat.
- frame_err  out  1  sticky: s_sof seen mid-frame. Cleared only by reset.

Behaviour:
- Reset: all shadow/active coefficients 0, div 0, alu_* 0, m_valid 0, m_data 0, m_last 0, commit_pending 0, frame_err 0, state IDLE.
- Two-stage pipeline. Stage 1 regs (st1_valid, alu_din, alu_kernel, alu_div, st1_last). Stage 2 regs (m_valid, m_data, m_last).
- adv2 = !m_valid || m_ready. adv1 = !st1_valid || adv2. s_ready = adv1 (combinational; 1 after reset).
- Beat accepted at edge k: stage 1 loaded at k; alu_dout captured into m_data at edge k+1 if adv2; m_valid high from k+1. Minimum latency 2 edges. Full throughput 1 beat/clock with m_ready=1.
- Stall: with m_valid && !m_ready, m_data/m_last hold; stage 1 holds if also full; s_ready drops. No beat is lost or duplicated.
- Stage 1 kernel/div are loaded from the active bank on every accepted beat. Active bank never changes mid-frame.
- Shadow write: cfg_we at edge writes shadow[cfg_addr]. cfg_addr > NTAPS is ignored. Writes are legal at any time.
- FSM states:
  - IDLE: no frame open. Accepted beat with s_sof → FRAME. Accepted s_sof&&s_last → stays IDLE.
  - FRAME: accepted s_last → IDLE. Accepted s_sof → set frame_err, treat as new frame start (swap rule applies).
  - Beat without s_sof in IDLE is processed normally; no state change.
- Commit rule:
  - cfg_commit sets commit_pending.
  - Swap (active ← shadow, commit_pending ← 0) occurs at the first edge where either (a) state is IDLE and no beat is accepted, or (b) a beat with s_sof is accepted; in case (b) that beat uses the new bank.
  - cfg_commit and qualifying event on the same edge: swap happens on that edge.
  - cfg_we and swap on the same edge: the written value is included in active.
  - cfg_commit while commit_pending: no extra effect.
- Arithmetic is entirely in the ALU. This block only registers its inputs and outputs.
- Reset mid-operation: pipeline contents are discarded, no m_valid is emitted afterwards, both banks are cleared.

Test Plan:
- Identity: tap4=+1, others 0, div 0, commit in IDLE. Send one window with center 0xABC, others 0xFFF → m_valid 2 edges after accept, m_data=0xABC, m_last echoes s_last.
- Box blur: all taps +1, div=3, all pixels 0x888 → per channel 9*8=72, 72>>3=9 → m_data=0x999. Stream 16 beats with m_ready=1 → 16 results back-to-back, 1 per clock.
- Negative clamp: tap4=-1 (5'b11111), others 0, center 0x5A3 → m_data=0x000.
- Backpressure: hold m_ready=0 for 5 cycles with s_valid=1 → s_ready low after 2 accepted beats, m_data stable. Release → exactly the sent beats, in order, none repeated.
- Deferred commit: mid-frame, write tap4=+2 and pulse cfg_commit → commit_pending=1, remaining beats use the old kernel. Next s_sof beat doubles the center value (center 0x333 → 0x666), and commit_pending clears on that edge.
- Framing error: two s_sof beats without an intervening s_last → frame_err=1 and stays set; deassert rst_n mid-stream → all outputs return to reset values asynchronously.
